// File: rtl/signed_mult_arbiter.sv
// Round-robin arbiter in front of one shared pipelined signed multiplier.
// Results return in grant order, tagged with the requester index.
module signed_mult_arbiter #(
  parameter int N    = 8,
  parameter int M    = N,
  parameter int R    = 4,
  parameter int LAT  = 2,
  parameter int ID_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req,
  input  logic [R*N-1:0]    a_in,
  input  logic [R*M-1:0]    b_in,
  output logic [R-1:0]      gnt,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [ID_W-1:0]   o_id,
  output logic [N+M-1:0]    o
);

  logic [ID_W-1:0]  r_ptr;
  logic             r_v1;
  logic [N-1:0]     r_a;
  logic [M-1:0]     r_b;
  logic [ID_W-1:0]  r_id1;
  logic [N+M-1:0]   r_p  [LAT-1];
  logic [ID_W-1:0]  r_id [LAT-1];
  logic             r_v  [LAT-1];

  logic             w_stall;
  logic             w_found;
  logic             w_fire;
  logic [ID_W-1:0]  w_gidx;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [N-1:0]     w_a;
  logic [M-1:0]     w_b;
  logic [N-1:0]     w_ma;
  logic [M-1:0]     w_mb;
  logic [N+M-1:0]   w_pu;
  logic [N+M-1:0]   w_prod;

  assign o_valid = r_v[LAT-2];
  assign o_id    = r_id[LAT-2];
  assign o       = r_p[LAT-2];
  assign w_stall = o_valid & ~o_ready;

  // first requester at or after the pointer, wrapping
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gidx  = '0;
    w_a     = '0;
    w_b     = '0;
    idx     = 0;
    for (int k = 0; k < R; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= R) idx = idx - R;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_gidx  = ID_W'(idx);
        w_a     = a_in[idx*N +: N];
        w_b     = b_in[idx*M +: M];
      end
    end
  end

  assign w_fire    = w_found & ~w_stall & ~rst;
  assign gnt       = w_fire ? (R'(1) << w_gidx) : '0;
  assign w_ptr_nxt = (w_gidx == ID_W'(R-1)) ? '0
                   : w_gidx + ID_W'(1);

  // magnitudes stay unsigned so -2^(N-1) maps to 2^(N-1) exactly
  assign w_ma   = r_a[N-1] ? -r_a : r_a;
  assign w_mb   = r_b[M-1] ? -r_b : r_b;
  assign w_pu   = {{M{1'b0}}, w_ma} * {{N{1'b0}}, w_mb};
  assign w_prod = (r_a[N-1] ^ r_b[M-1]) ? -w_pu : w_pu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_v1  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_id1 <= '0;
      for (int s = 0; s < LAT-1; s++) begin
        r_p[s]  <= '0;
        r_id[s] <= '0;
        r_v[s]  <= 1'b0;
      end
    end else if (!w_stall) begin
      if (w_fire) r_ptr <= w_ptr_nxt;
      r_v1    <= w_fire;
      r_a     <= w_a;
      r_b     <= w_b;
      r_id1   <= w_gidx;
      r_p[0]  <= w_prod;
      r_id[0] <= r_id1;
      r_v[0]  <= r_v1;
      for (int s = 1; s < LAT-1; s++) begin
        r_p[s]  <= r_p[s-1];
        r_id[s] <= r_id[s-1];
        r_v[s]  <= r_v[s-1];
      end
    end
  end

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Random and directed checks of signed_mult_arbiter against
// a queue-based model of grants, ordering and products.
module tb_signed_mult_arbiter;

  localparam int N   = 8;
  localparam int M   = 8;
  localparam int R   = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [R-1:0]      req;
  logic [R*N-1:0]    a_in;
  logic [R*M-1:0]    b_in;
  logic [R-1:0]      gnt;
  logic              o_valid;
  logic              o_ready;
  logic [IW-1:0]     o_id;
  logic [N+M-1:0]    o;

  signed_mult_arbiter #(.N(N), .M(M), .R(R), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_id(o_id), .o(o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int p;
    int age;
  } ent_t;

  ent_t         q[$];
  int           ptr;
  int           n_vec;
  int           n_err;
  logic [R-1:0] exp_gnt;
  logic         stall;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [R-1:0] rr(logic [R-1:0] r,
                                      int p);
    for (int k = 0; k < R; k++) begin
      int i;
      i = (p + k) % R;
      if (r[i]) return R'(1) << i;
    end
    return '0;
  endfunction

  function automatic int prod(int i);
    logic [N-1:0] a;
    logic [M-1:0] b;
    a = a_in[i*N +: N];
    b = b_in[i*M +: M];
    return int'($signed(a)) * int'($signed(b));
  endfunction

  task automatic set_op(int i, logic [N-1:0] a,
                        logic [M-1:0] b);
    a_in[i*N +: N] = a;
    b_in[i*M +: M] = b;
  endtask

  // one clock: check current outputs, then advance the model
  task automatic cycle();
    logic ev;
    #1;
    ev      = (q.size() > 0) && (q[0].age == LAT);
    stall   = ev & ~o_ready;
    exp_gnt = (rst || stall) ? '0 : rr(req, ptr);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("o_valid", 32'(o_valid), 32'(ev));
    if (ev) begin
      check("o", 32'(o), 32'(q[0].p & 32'hFFFF));
      check("o_id", 32'(o_id), 32'(q[0].id));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      ptr = 0;
    end else if (!stall) begin
      if (ev) void'(q.pop_front());
      foreach (q[j]) q[j].age++;
      for (int i = 0; i < R; i++) begin
        if (exp_gnt[i]) begin
          q.push_back('{i, prod(i), 1});
          ptr = (i + 1) % R;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] expv [3];
    int k;
    n_vec   = 0;
    n_err   = 0;
    ptr     = 0;
    exp_gnt = '0;
    rst     = 1'b1;
    req     = 4'b1111;
    o_ready = 1'b1;
    a_in    = '0;
    b_in    = '0;
    @(posedge clk);
    #1;

    // reset with all requesting
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("rst_o", 32'(o), 32'h0);
      check("rst_oid", 32'(o_id), 32'h0);
    end
    rst = 1'b0;
    #1;
    check("first_gnt", 32'(gnt), 32'h1);
    req = '0;
    cycle();
    for (int c = 0; c < 4; c++) cycle();

    // signed products from requester 0
    do_reset();
    expv[0] = 16'hFFF1;
    expv[1] = 16'h4000;
    expv[2] = 16'hC080;
    k = 0;
    req = 4'b0001;
    set_op(0, 8'hFD, 8'h05);
    cycle();
    set_op(0, 8'h80, 8'h80);
    cycle();
    if (o_valid) begin
      check("sgn", 32'(o), 32'(expv[k]));
      k++;
    end
    set_op(0, 8'h7F, 8'h80);
    cycle();
    req = '0;
    for (int c = 0; c < 3; c++) begin
      if (o_valid && k < 3) begin
        check("sgn", 32'(o), 32'(expv[k]));
        check("sgn_id", 32'(o_id), 32'h0);
        k++;
      end
      cycle();
    end
    check("sgn_cnt", 32'(k), 32'd3);

    // round-robin, all requesting
    do_reset();
    for (int i = 0; i < R; i++) set_op(i, 8'(i + 1), 8'(i + 3));
    req = 4'b1111;
    for (int c = 0; c < 5; c++) cycle();
    req = '0;
    for (int c = 0; c < 4; c++) cycle();

    // round-robin, sparse
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 4; c++) cycle();
    req = '0;
    for (int c = 0; c < 4; c++) cycle();

    // backpressure on a full pipeline
    req = 4'b1111;
    for (int c = 0; c < 4; c++) cycle();
    o_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    o_ready = 1'b1;
    for (int c = 0; c < 2; c++) cycle();
    req = '0;
    for (int c = 0; c < 5; c++) cycle();

    // reset mid-flight
    req = 4'b1111;
    cycle();
    cycle();
    req = '0;
    cycle();
    do_reset();
    req = 4'b0001;
    set_op(0, 8'h11, 8'hF0);
    cycle();
    req = '0;
    for (int c = 0; c < 4; c++) cycle();

    // random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      o_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < R; i++) begin
        if (exp_gnt[i] || !req[i]) begin
          req[i] = $urandom_range(0, 1) == 1;
          set_op(i, 8'($urandom), 8'($urandom));
        end
      end
      cycle();
    end
    rst     = 1'b0;
    req     = '0;
    o_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    check("drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/signed_mult_arbiter.md
# signed_mult_arbiter

Shares one pipelined signed (two's-complement) multiplier between `R` requesters. It uses round-robin arbitration, a per-requester request/grant handshake, and an output valid/ready handshake with full-pipeline backpressure. It sits between multiple datapath clients (e.g. MAC/filter sequencers) and a single multiplier resource, so the design needs only one N×M signed multiplier. Each result is returned tagged with the requester index.

## Interface
Parameters:
- `N`, 8, width of operand A per requester (signed).
- `M`, `N`, width of operand B per requester (signed).
- `R`, 4, number of requesters (≥2).
- `LAT`, 2, grant-to-result latency in cycles (≥2).
- `ID_W`, `max(1, clog2(R))`, width of the result tag.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  R  `req[i]` high = requester i has valid operands presented.
- `a_in`  in  R*N  operand A of requester i at bits `[i*N +: N]`.
- `b_in`  in  R*M  operand B of requester i at bits `[i*M +: M]`.
- `gnt`  out  R  one-hot or zero; `gnt[i]` high = requester i's operands are captured at this edge.
- `o_valid`  out  1  result available.
- `o_ready`  in  1  consumer accepts result this cycle.
- `o_id`  out  ID_W  index of the requester that owns `o`.
- `o`  out  N+M  signed product, full width.

## Operation
- **Handshake (requester side)**
  - Requester i holds `req[i]`, `a_in`, `b_in` stable until it sees `gnt[i]` high.
  - The transfer completes in the cycle `gnt[i]` is high.
  - The requester may drop or change `req[i]` in the following cycle.
- **Grant logic**
  - `gnt` is combinational from `req`, the round-robin pointer `ptr` and `stall`.
  - Grant goes to the first i with `req[i]=1`, searching `ptr, ptr+1, …, R-1, 0, …, ptr-1`.
  - Grant is 0 when `stall` or `rst` is high, or when `req=0`.
  - `gnt` never has more than one bit set.
- **Pointer**
  - On a grant to i, `ptr <= (i+1) mod R`.
  - With no grant, `ptr` holds.
- **Stall**
  - `stall = o_valid & ~o_ready`.
  - While stalled, every pipeline register holds its value and no grant issues.
  - When not stalled, all stages advance every cycle; bubbles propagate as `valid=0`.
- **Pipeline**
  - Stage 1 registers the granted operands, the id, and `valid = |gnt`.
  - The product is computed from stage 1 in sign-magnitude form:
    - negate each negative operand,
    - take the unsigned N×M product,
    - negate the product when `a[N-1]^b[M-1]`.
  - Stages 2..LAT register product, id and valid. `o`, `o_id`, `o_valid` come directly from stage LAT.
- **Arithmetic**
  - The result is always exact in N+M bits; no saturation and no overflow flag.
  - Corner case: `-2^(N-1) * -2^(M-1) = +2^(N+M-2)` must be exact. Its magnitude operand `2^(N-1)` is treated as unsigned.
- **Reset**
  - `ptr=0`; all stage valids 0; `o=0`, `o_id=0`, `o_valid=0`; `gnt=0`.
  - Reset mid-operation discards all in-flight results. No result from before reset may appear afterwards.
- **Simultaneous events**
  - Output handshake at edge t (`o_valid & o_ready`) and a new grant in cycle t are both allowed; the pipeline advances.
  - `req` deasserted without a grant is legal; nothing is captured.

## Timing
- Grant in cycle t → `o_valid` high in cycle t+LAT with that request's product, absent stalls.
- Each stall cycle adds exactly one cycle to every in-flight result.
- Throughput: one grant per cycle while `o_ready=1`.
- Results leave in grant order; no reordering.
- `gnt` settles combinationally within the cycle. Requesters must not derive `req` combinationally from `gnt`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req=4'b1111`.
  - → `gnt=0`, `o_valid=0`, `o=0`, `o_id=0` throughout.
  - → first grant after release is `gnt=4'b0001`.
- **Signed products:** N=M=8, LAT=2, `o_ready=1`; single requester 0 issues three requests: (-3, 5), (-128, -128), (127, -128).
  - → `o` = `16'hFFF1`, `16'h4000`, `16'hC080` on cycles t+2, t+3, t+4.
  - → `o_id=0` for each result.
- **Round-robin, all requesting:** `req=4'b1111` held constantly.
  - → `gnt` sequence `0001, 0010, 0100, 1000, 0001`.
  - → `o_id` sequence 0,1,2,3,0 appears LAT cycles later.
- **Round-robin, sparse:** `req=4'b1010` held, `ptr=0`.
  - → `gnt` sequence `0010, 1000, 0010, 1000`.
  - → requesters 0 and 2 are never granted.
- **Backpressure:** full pipeline, drop `o_ready` for 3 cycles.
  - → `gnt=0` and `o`/`o_id` stable for those 3 cycles.
  - → after release, results resume in order with none lost or duplicated.
- **Reset mid-flight:** assert `rst` one cycle after 2 grants.
  - → no `o_valid` for the discarded requests.
  - → the next post-reset grant's result arrives exactly LAT cycles after its grant.
